alu_share_arbiter: RTL and testbench

- Shares one combinational 32-bit ALU instance between two requesters, e.g. the main execute stage and the branch-compare / address-calculation path.
- Arbitrates round-robin using a valid/ready handshake on each request port.
- Captures the ALU output into a single-entry registered response slot, with a requester ID tag, for a downstream valid/ready consumer.
- Sustains one operation per cycle when the consumer never stalls.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_share_arbiter_alu.sv | 33 +++
 rtl/alu_share_arbiter_rr_arbiter2.sv | 59 +++++
 rtl/alu_share_arbiter.sv | 173 +++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code constants, default widths, requester IDs,
// response slot state encoding and signed-overflow helpers.
// Optional feature macro used by the top: ALU_SHARE_OVERFLOW_EN.
package alu_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int SEL_WIDTH_DEF  = 4;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic REQ_EXEC = 1'b0;
  localparam logic REQ_AUX  = 1'b1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Signed overflow on addition: operands agree in sign, result does not.
  function automatic logic add_overflow(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  // Signed overflow on subtraction: operands differ in sign, result sign differs from operand A.
  function automatic logic sub_overflow(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational 32-bit ALU shared by the arbiter. Unknown op codes yield 0.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SEL_WIDTH  = SEL_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  logic [SEL_WIDTH-1:0]  alu_select,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero_flag
);

  logic [DATA_WIDTH-1:0] result_s;

  // Operation decode; SLT is an unsigned compare producing 1/0.
  always_comb begin
    result_s = {DATA_WIDTH{1'b0}};
    case (alu_select)
      ALU_AND: result_s = operand1 & operand2;
      ALU_OR:  result_s = operand1 | operand2;
      ALU_ADD: result_s = operand1 + operand2;
      ALU_SUB: result_s = operand1 - operand2;
      ALU_SLT: result_s = {{(DATA_WIDTH-1){1'b0}}, (operand1 < operand2)};
      default: result_s = {DATA_WIDTH{1'b0}};
    endcase
  end

  assign result    = result_s;
  assign zero_flag = (result_s == {DATA_WIDTH{1'b0}});

endmodule

// File: rtl/alu_share_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter. Grants are combinational and only issued
// while enabled; the last_grant register moves only when a grant is given,
// which the top treats as an accept (a grant implies the request is valid).
module rr_arbiter2 #(
  parameter bit FIRST_PRIORITY = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic req0,
  input  logic req1,
  output logic grant0,
  output logic grant1
);

  logic last_grant_r;
  logic grant0_s;
  logic grant1_s;

  // Grant selection: a lone requester wins; on contention the one not granted last wins.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (enable) begin
      if (req0 && !req1) begin
        grant0_s = 1'b1;
      end else if (req1 && !req0) begin
        grant1_s = 1'b1;
      end else if (req0 && req1) begin
        if (last_grant_r) begin
          grant0_s = 1'b1;
        end else begin
          grant1_s = 1'b1;
        end
      end else begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Priority pointer: reset so FIRST_PRIORITY wins first, then track the last winner.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_r <= ~FIRST_PRIORITY;
    end else if (grant0_s) begin
      last_grant_r <= 1'b0;
    end else if (grant1_s) begin
      last_grant_r <= 1'b1;
    end
  end

  assign grant0 = grant0_s;
  assign grant1 = grant1_s;

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two valid/ready requesters with round-robin
// arbitration and a single-entry registered response slot tagged with the
// requester ID. Optional macro ALU_SHARE_OVERFLOW_EN adds rsp_overflow.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int SEL_WIDTH      = SEL_WIDTH_DEF,
  parameter int FIRST_PRIORITY = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_operand1,
  input  logic [DATA_WIDTH-1:0] req0_operand2,
  input  logic [SEL_WIDTH-1:0]  req0_alu_select,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_operand1,
  input  logic [DATA_WIDTH-1:0] req1_operand2,
  input  logic [SEL_WIDTH-1:0]  req1_alu_select,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_zero_flag
`ifdef ALU_SHARE_OVERFLOW_EN
  ,
  output logic                  rsp_overflow
`endif
);

  slot_state_t           state_r;
  slot_state_t           state_next_s;
  logic                  can_accept_s;
  logic                  grant0_s;
  logic                  grant1_s;
  logic                  accept_s;
  logic [DATA_WIDTH-1:0] alu_a_s;
  logic [DATA_WIDTH-1:0] alu_b_s;
  logic [SEL_WIDTH-1:0]  alu_sel_s;
  logic [DATA_WIDTH-1:0] alu_result_s;
  logic                  alu_zero_s;
  logic                  rsp_id_r;
  logic [DATA_WIDTH-1:0] rsp_result_r;
  logic                  rsp_zero_r;

  // Reset blocks acceptance so nothing issued in the reset cycle produces a response.
  assign can_accept_s = !reset && ((state_r == SLOT_EMPTY) || rsp_ready);

  rr_arbiter2 #(
    .FIRST_PRIORITY (FIRST_PRIORITY != 0)
  ) u_arb (
    .clk    (clk),
    .reset  (reset),
    .enable (can_accept_s),
    .req0   (req0_valid),
    .req1   (req1_valid),
    .grant0 (grant0_s),
    .grant1 (grant1_s)
  );

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign accept_s   = (req0_valid && grant0_s) || (req1_valid && grant1_s);

  // Operand mux: route the granted requester into the shared ALU.
  always_comb begin
    if (grant1_s) begin
      alu_a_s   = req1_operand1;
      alu_b_s   = req1_operand2;
      alu_sel_s = req1_alu_select;
    end else begin
      alu_a_s   = req0_operand1;
      alu_b_s   = req0_operand2;
      alu_sel_s = req0_alu_select;
    end
  end

  alu #(
    .DATA_WIDTH (DATA_WIDTH),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_alu (
    .operand1   (alu_a_s),
    .operand2   (alu_b_s),
    .alu_select (alu_sel_s),
    .result     (alu_result_s),
    .zero_flag  (alu_zero_s)
  );

  // Slot next state: fill on accept, drain when consumed without a refill.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      SLOT_EMPTY: begin
        if (accept_s) begin
          state_next_s = SLOT_FULL;
        end else begin
          state_next_s = SLOT_EMPTY;
        end
      end
      SLOT_FULL: begin
        if (rsp_ready) begin
          if (accept_s) begin
            state_next_s = SLOT_FULL;
          end else begin
            state_next_s = SLOT_EMPTY;
          end
        end else begin
          state_next_s = SLOT_FULL;
        end
      end
      default: state_next_s = SLOT_EMPTY;
    endcase
  end

  // Slot state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= SLOT_EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Response payload: loaded only on accept, so it stays frozen under backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_id_r     <= 1'b0;
      rsp_result_r <= {DATA_WIDTH{1'b0}};
      rsp_zero_r   <= 1'b0;
    end else if (accept_s) begin
      rsp_id_r     <= grant1_s;
      rsp_result_r <= alu_result_s;
      rsp_zero_r   <= alu_zero_s;
    end
  end

`ifdef ALU_SHARE_OVERFLOW_EN
  logic ovf_s;
  logic rsp_ovf_r;

  // Signed overflow detection for ADD and SUB on the granted operands.
  always_comb begin
    ovf_s = 1'b0;
    case (alu_sel_s)
      ALU_ADD: ovf_s = add_overflow(alu_a_s[DATA_WIDTH-1], alu_b_s[DATA_WIDTH-1],
                                    alu_result_s[DATA_WIDTH-1]);
      ALU_SUB: ovf_s = sub_overflow(alu_a_s[DATA_WIDTH-1], alu_b_s[DATA_WIDTH-1],
                                    alu_result_s[DATA_WIDTH-1]);
      default: ovf_s = 1'b0;
    endcase
  end

  // Overflow flag registered alongside the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_ovf_r <= 1'b0;
    end else if (accept_s) begin
      rsp_ovf_r <= ovf_s;
    end
  end

  assign rsp_overflow = rsp_ovf_r;
`endif

  assign rsp_valid     = (state_r == SLOT_FULL);
  assign rsp_id        = rsp_id_r;
  assign rsp_result    = rsp_result_r;
  assign rsp_zero_flag = rsp_zero_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed testbench for alu_share_arbiter: reset state, single ops, contention,
// backpressure, edge ops, reset while full, and stall-preserved priority.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_operand1, req0_operand2, req1_operand1, req1_operand2;
  logic [3:0]  req0_alu_select, req1_alu_select;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero_flag;
  logic [31:0] rsp_result;
`ifdef ALU_SHARE_OVERFLOW_EN
  logic        rsp_overflow;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(
    .DATA_WIDTH     (32),
    .SEL_WIDTH      (4),
    .FIRST_PRIORITY (0)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req0_valid      (req0_valid),
    .req0_ready      (req0_ready),
    .req0_operand1   (req0_operand1),
    .req0_operand2   (req0_operand2),
    .req0_alu_select (req0_alu_select),
    .req1_valid      (req1_valid),
    .req1_ready      (req1_ready),
    .req1_operand1   (req1_operand1),
    .req1_operand2   (req1_operand2),
    .req1_alu_select (req1_alu_select),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_id          (rsp_id),
    .rsp_result      (rsp_result),
    .rsp_zero_flag   (rsp_zero_flag)
`ifdef ALU_SHARE_OVERFLOW_EN
    ,
    .rsp_overflow    (rsp_overflow)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel);
    if (id) begin
      req1_valid = 1'b1; req1_operand1 = a; req1_operand2 = b; req1_alu_select = sel;
    end else begin
      req0_valid = 1'b1; req0_operand1 = a; req0_operand2 = b; req0_alu_select = sel;
    end
  endtask

  // One uncontended operation with rsp_ready high; response checked next cycle.
  task automatic single(input string tag, input bit id, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] sel, input logic [31:0] er, input logic ez, input logic eo);
    drive(id, a, b, sel);
    #1;
    check({tag, ".ready0"}, {31'd0, req0_ready}, {31'd0, ~id});
    check({tag, ".ready1"}, {31'd0, req1_ready}, {31'd0, id});
    tick;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check({tag, ".valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, ".id"}, {31'd0, rsp_id}, {31'd0, id});
    check({tag, ".result"}, rsp_result, er);
    check({tag, ".zero"}, {31'd0, rsp_zero_flag}, {31'd0, ez});
`ifdef ALU_SHARE_OVERFLOW_EN
    check({tag, ".ovf"}, {31'd0, rsp_overflow}, {31'd0, eo});
`else
    if (eo) begin end
`endif
  endtask

  initial begin
    reset = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_operand1 = 32'd0; req0_operand2 = 32'd0; req0_alu_select = 4'd0;
    req1_operand1 = 32'd0; req1_operand2 = 32'd0; req1_alu_select = 4'd0;
    tick;
    // Readies must stay low while reset is asserted even with valid requests.
    drive(1'b0, 32'd1, 32'd1, ALU_ADD);
    drive(1'b1, 32'd1, 32'd1, ALU_ADD);
    #1;
    check("rst.ready0", {31'd0, req0_ready}, 32'd0);
    check("rst.ready1", {31'd0, req1_ready}, 32'd0);
    tick;
    check("rst.valid", {31'd0, rsp_valid}, 32'd0);
    check("rst.id", {31'd0, rsp_id}, 32'd0);
    check("rst.result", rsp_result, 32'd0);
    check("rst.zero", {31'd0, rsp_zero_flag}, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b0;
    tick;

    single("add5_7", 1'b0, 32'd5, 32'd7, ALU_ADD, 32'd12, 1'b0, 1'b0);
    tick;
    check("drain.valid", {31'd0, rsp_valid}, 32'd0);

    // Contention straight after reset: ids alternate 0,1,0,1.
    reset = 1'b1;
    tick;
    reset = 1'b0;
    drive(1'b0, 32'd9, 32'd9, ALU_SUB);
    drive(1'b1, 32'h0000_00F0, 32'h0000_000F, ALU_OR);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("cont.ready0", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("cont.ready1", {31'd0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      tick;
      check("cont.id", {31'd0, rsp_id}, (i % 2 == 1) ? 32'd1 : 32'd0);
      check("cont.result", rsp_result, (i % 2 == 1) ? 32'h0000_00FF : 32'd0);
      check("cont.zero", {31'd0, rsp_zero_flag}, (i % 2 == 1) ? 32'd0 : 32'd1);
    end

    // Backpressure: slot holds id1/0xFF, req1 waits three cycles.
    rsp_ready = 1'b0;
    req0_valid = 1'b0;
    drive(1'b1, 32'hFFFF_FFFF, 32'd1, ALU_ADD);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp.ready1", {31'd0, req1_ready}, 32'd0);
      check("bp.valid", {31'd0, rsp_valid}, 32'd1);
      check("bp.id", {31'd0, rsp_id}, 32'd1);
      check("bp.result", rsp_result, 32'h0000_00FF);
      tick;
    end
    rsp_ready = 1'b1;
    #1;
    check("bp.rel.ready1", {31'd0, req1_ready}, 32'd1);
    check("bp.rel.ready0", {31'd0, req0_ready}, 32'd0);
    tick;
    req1_valid = 1'b0;
    check("bp.rsp.valid", {31'd0, rsp_valid}, 32'd1);
    check("bp.rsp.id", {31'd0, rsp_id}, 32'd1);
    check("bp.rsp.result", rsp_result, 32'd0);
    check("bp.rsp.zero", {31'd0, rsp_zero_flag}, 32'd1);

    // Edge operations, back-to-back through the full slot.
    single("slt_max_1", 1'b1, 32'hFFFF_FFFF, 32'd1, ALU_SLT, 32'd0, 1'b1, 1'b0);
    single("slt_1_max", 1'b0, 32'd1, 32'hFFFF_FFFF, ALU_SLT, 32'd1, 1'b0, 1'b0);
    single("and", 1'b0, 32'h0000_F0F0, 32'h0000_FF00, ALU_AND, 32'h0000_F000, 1'b0, 1'b0);
    single("sub3_5", 1'b1, 32'd3, 32'd5, ALU_SUB, 32'hFFFF_FFFE, 1'b0, 1'b0);
    single("sel_f", 1'b0, 32'd3, 32'd5, 4'b1111, 32'd0, 1'b1, 1'b0);
    single("sel_3", 1'b1, 32'd3, 32'd5, 4'b0011, 32'd0, 1'b1, 1'b0);
    single("add_ovf", 1'b0, 32'h7FFF_FFFF, 32'd1, ALU_ADD, 32'h8000_0000, 1'b0, 1'b1);
    single("sub_ovf", 1'b1, 32'h8000_0000, 32'd1, ALU_SUB, 32'h7FFF_FFFF, 1'b0, 1'b1);
    single("add_noovf", 1'b0, 32'd1, 32'd1, ALU_ADD, 32'd2, 1'b0, 1'b0);

    // Reset while FULL with both valid; last winner was 0, reset restores priority to 0.
    drive(1'b0, 32'd2, 32'd3, ALU_ADD);
    drive(1'b1, 32'h0000_0010, 32'h0000_0001, ALU_OR);
    reset = 1'b1;
    #1;
    check("rstf.ready0", {31'd0, req0_ready}, 32'd0);
    check("rstf.ready1", {31'd0, req1_ready}, 32'd0);
    tick;
    check("rstf.valid", {31'd0, rsp_valid}, 32'd0);
    check("rstf.result", rsp_result, 32'd0);
    reset = 1'b0;
    #1;
    check("rstf.first.ready0", {31'd0, req0_ready}, 32'd1);
    check("rstf.first.ready1", {31'd0, req1_ready}, 32'd0);
    tick;
    check("rstf.rsp.id", {31'd0, rsp_id}, 32'd0);
    check("rstf.rsp.result", rsp_result, 32'd5);

    // Stall with both valid must not rotate priority: requester 1 is next.
    rsp_ready = 1'b0;
    #1;
    check("stall.ready0", {31'd0, req0_ready}, 32'd0);
    check("stall.ready1", {31'd0, req1_ready}, 32'd0);
    tick;
    tick;
    check("stall.id", {31'd0, rsp_id}, 32'd0);
    rsp_ready = 1'b1;
    #1;
    check("stall.rel.ready1", {31'd0, req1_ready}, 32'd1);
    check("stall.rel.ready0", {31'd0, req0_ready}, 32'd0);
    tick;
    check("stall.rsp.id", {31'd0, rsp_id}, 32'd1);
    check("stall.rsp.result", rsp_result, 32'h0000_0011);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick;
    check("end.valid", {31'd0, rsp_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
